// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// The enum selects between the registered-read and first-word-fall-through read paths.
package fifo_pkg;
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  typedef logic [ASIZE_DEF:0] count_t;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int depth_of(input int asize);
    return 1 << asize;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM for the FIFO: synchronous write port and a read port.
// The read port can be registered (standard reads) or combinational (feeds the FWFT head register).
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int ASIZE   = ASIZE_DEF,
  parameter bit SYNC_RD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_re,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);
  localparam int DEPTH = depth_of(ASIZE);

  logic [DSIZE-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  if (SYNC_RD) begin : g_sync_rd
    logic [DSIZE-1:0] r_rdata;

    always_ff @(posedge clk) begin
      if (rst)       r_rdata <= '0;
      else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
  end else begin : g_async_rd
    logic w_unused;

    assign w_unused = rst ^ i_re;
    assign o_rdata  = r_mem[i_raddr];
  end
endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: pointers, occupancy count, registered status flags,
// sticky error flags and an optional first-word-fall-through head register.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEF,
  parameter int ASIZE      = ASIZE_DEF,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = (1 << ASIZE) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             wafull,
  output logic             wovf,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             raempty,
  output logic             rudf,
  output logic [ASIZE:0]   count,
  input  logic             clr_err
);
  localparam int DEPTH = depth_of(ASIZE);
  localparam fifo_mode_e MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;
  localparam logic [ASIZE:0]   C_DEPTH  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0]   C_AFULL  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0]   C_AEMPTY = (ASIZE+1)'(AEMPTY_LVL);
  localparam logic [ASIZE:0]   C_ONE    = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] C_PINC   = ASIZE'(1);

  logic [ASIZE-1:0] r_wptr;
  logic [ASIZE-1:0] r_rptr;
  logic [ASIZE:0]   r_count;
  logic [ASIZE:0]   w_count_nxt;
  logic             r_wfull;
  logic             r_wafull;
  logic             r_rempty;
  logic             r_raempty;
  logic             r_wovf;
  logic             r_rudf;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_mem_re;
  logic [DSIZE-1:0] w_mem_rdata;

  // Acceptance looks only at registered flags, which gives the full/empty precedence for free.
  assign w_wr_acc = winc && !r_wfull && !rst;
  assign w_rd_acc = rinc && !r_rempty && !rst;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + C_ONE;
    else if (!w_wr_acc && w_rd_acc) w_count_nxt = r_count - C_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_wfull   <= 1'b0;
      r_wafull  <= 1'b0;
      r_raempty <= 1'b1;
      r_wovf    <= 1'b0;
      r_rudf    <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + C_PINC;
      if (w_mem_re) r_rptr <= r_rptr + C_PINC;
      r_count   <= w_count_nxt;
      r_wfull   <= (w_count_nxt == C_DEPTH);
      r_wafull  <= (w_count_nxt >= C_AFULL);
      r_raempty <= (w_count_nxt <= C_AEMPTY);
      // A new error in the same cycle as clr_err keeps the flag set.
      r_wovf    <= (winc && r_wfull) || (r_wovf && !clr_err);
      r_rudf    <= (rinc && r_rempty) || (r_rudf && !clr_err);
    end
  end

  fifo_mem #(
    .DSIZE  (DSIZE),
    .ASIZE  (ASIZE),
    .SYNC_RD(MODE == MODE_STD)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_wr_acc),
    .i_waddr(r_wptr),
    .i_wdata(wdata),
    .i_re   (w_mem_re),
    .i_raddr(r_rptr),
    .o_rdata(w_mem_rdata)
  );

  if (MODE == MODE_STD) begin : g_std
    assign w_mem_re = w_rd_acc;
    assign rdata    = w_mem_rdata;

    always_ff @(posedge clk) begin
      if (rst) r_rempty <= 1'b1;
      else     r_rempty <= (w_count_nxt == '0);
    end
  end else begin : g_fwft
    logic [DSIZE-1:0] r_odata;
    logic             w_mem_empty;

    // count includes the head word, so memory is empty when count equals head-valid.
    assign w_mem_empty = (r_count == {{ASIZE{1'b0}}, !r_rempty});
    assign w_mem_re    = !rst && !w_mem_empty && (r_rempty || w_rd_acc);
    assign rdata       = r_odata;

    // r_rempty doubles as the inverted head-valid bit.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_odata  <= '0;
        r_rempty <= 1'b1;
      end else if (w_mem_re) begin
        r_odata  <= w_mem_rdata;
        r_rempty <= 1'b0;
      end else if (w_rd_acc) begin
        r_rempty <= 1'b1;
      end
    end
  end

  assign wfull   = r_wfull;
  assign wafull  = r_wafull;
  assign wovf    = r_wovf;
  assign rempty  = r_rempty;
  assign raempty = r_raempty;
  assign rudf    = r_rudf;
  assign count   = r_count;

  a_not_full_and_empty: assert property (@(posedge clk) disable iff (rst) !(r_wfull && r_rempty));
  a_count_in_range:     assert property (@(posedge clk) disable iff (rst) r_count <= C_DEPTH);
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Self-checking bench for sync_fifo_ctl: one standard-mode and one FWFT-mode instance,
// with a data scoreboard queue filled on accepted writes and drained on observed reads.
module tb_sync_fifo_ctl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  logic          s_winc, s_rinc, s_clr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          s_wfull, s_wafull, s_wovf, s_rempty, s_raempty, s_rudf;
  logic [AW:0]   s_count;

  logic          f_winc, f_rinc, f_clr;
  logic [DW-1:0] f_wdata, f_rdata;
  logic          f_wfull, f_wafull, f_wovf, f_rempty, f_raempty, f_rudf;
  logic [AW:0]   f_count;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  sync_fifo_ctl #(.DSIZE(DW), .ASIZE(AW), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .winc(s_winc), .wdata(s_wdata), .wfull(s_wfull), .wafull(s_wafull),
    .wovf(s_wovf), .rinc(s_rinc), .rdata(s_rdata), .rempty(s_rempty), .raempty(s_raempty),
    .rudf(s_rudf), .count(s_count), .clr_err(s_clr)
  );

  sync_fifo_ctl #(.DSIZE(DW), .ASIZE(AW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull), .wafull(f_wafull),
    .wovf(f_wovf), .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty), .raempty(f_raempty),
    .rudf(f_rudf), .count(f_count), .clr_err(f_clr)
  );

  // Outputs are sampled 1 time unit after the edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_winc = 0; s_rinc = 0; s_clr = 0; s_wdata = '0;
    f_winc = 0; f_rinc = 0; f_clr = 0; f_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({s_count, s_wfull, s_wafull, s_rempty, s_raempty, s_wovf, s_rudf, s_rdata} !==
        {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL std_reset got cnt=%0d wf=%b waf=%b re=%b rae=%b ovf=%b udf=%b rd=%h",
               s_count, s_wfull, s_wafull, s_rempty, s_raempty, s_wovf, s_rudf, s_rdata);
    end
    checks++;
    if ({f_count, f_wfull, f_wafull, f_rempty, f_raempty, f_wovf, f_rudf, f_rdata} !==
        {5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL fwft_reset got cnt=%0d wf=%b waf=%b re=%b rae=%b ovf=%b udf=%b rd=%h",
               f_count, f_wfull, f_wafull, f_rempty, f_raempty, f_wovf, f_rudf, f_rdata);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      s_winc = 1; s_wdata = DW'(i);
      sb.push_back(DW'(i));
      tick();
      checks++;
      if ({s_count, s_wafull, s_wfull, s_rempty} !== {5'(i + 1), (i + 1 >= 14), (i + 1 == 16), 1'b0}) begin
        failures++;
        $display("FAIL fill_%0d got cnt=%0d waf=%b wf=%b re=%b want cnt=%0d", i, s_count,
                 s_wafull, s_wfull, s_rempty, i + 1);
      end
    end
    s_wdata = 8'hEE;
    tick();
    s_winc = 0;
    checks++;
    if ({s_wovf, s_wfull, s_count} !== {1'b1, 1'b1, 5'd16}) begin
      failures++;
      $display("FAIL overflow got ovf=%b wf=%b cnt=%0d want 1 1 16", s_wovf, s_wfull, s_count);
    end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp;
    exp = '0;
    s_rinc = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp = sb.pop_front();
      checks++;
      if ({s_rdata, s_count, s_rempty, s_raempty} !== {exp, 5'(15 - i), (i == 15), (15 - i <= 2)}) begin
        failures++;
        $display("FAIL drain_%0d got rd=%h cnt=%0d re=%b rae=%b want rd=%h cnt=%0d", i,
                 s_rdata, s_count, s_rempty, s_raempty, exp, 15 - i);
      end
    end
    tick();
    s_rinc = 0;
    checks++;
    if ({s_rudf, s_count, s_rdata} !== {1'b1, 5'd0, exp}) begin
      failures++;
      $display("FAIL underflow got udf=%b cnt=%0d rd=%h want 1 0 %h", s_rudf, s_count, s_rdata, exp);
    end
    s_clr = 1; s_rinc = 1;
    tick();
    s_rinc = 0;
    checks++;
    if ({s_wovf, s_rudf} !== 2'b01) begin
      failures++;
      $display("FAIL clr_set_wins got ovf=%b udf=%b want 0 1", s_wovf, s_rudf);
    end
    tick();
    s_clr = 0;
    checks++;
    if ({s_wovf, s_rudf} !== 2'b00) begin
      failures++;
      $display("FAIL clr_err got ovf=%b udf=%b want 0 0", s_wovf, s_rudf);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] exp;
    for (int i = 0; i < 16; i++) begin
      s_winc = 1; s_wdata = DW'(8'h40 + i);
      sb.push_back(DW'(8'h40 + i));
      tick();
    end
    s_winc = 1; s_rinc = 1; s_wdata = 8'hBB;
    tick();
    s_winc = 0; s_rinc = 0;
    exp = sb.pop_front();
    checks++;
    if ({s_count, s_wovf, s_wfull, s_rdata} !== {5'd15, 1'b1, 1'b0, exp}) begin
      failures++;
      $display("FAIL both_at_full got cnt=%0d ovf=%b wf=%b rd=%h want 15 1 0 %h",
               s_count, s_wovf, s_wfull, s_rdata, exp);
    end
    s_clr = 1;
    tick();
    s_clr = 0;
    s_rinc = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      exp = sb.pop_front();
      checks++;
      if (s_rdata !== exp) begin
        failures++;
        $display("FAIL simul_drain_%0d got rd=%h want %h", i, s_rdata, exp);
      end
    end
    s_winc = 1; s_wdata = 8'hCC;
    sb.push_back(8'hCC);
    tick();
    s_winc = 0; s_rinc = 0;
    checks++;
    if ({s_count, s_rudf, s_rempty, s_wovf} !== {5'd1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL both_at_empty got cnt=%0d udf=%b re=%b ovf=%b want 1 1 0 0",
               s_count, s_rudf, s_rempty, s_wovf);
    end
    s_rinc = 1; s_clr = 1;
    tick();
    s_rinc = 0; s_clr = 0;
    exp = sb.pop_front();
    checks++;
    if ({s_rdata, s_count} !== {exp, 5'd0}) begin
      failures++;
      $display("FAIL after_empty_write got rd=%h cnt=%0d want %h 0", s_rdata, s_count, exp);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
    int bad;
    bad = 0;
    s_winc = 1;
    for (int i = 0; i < 3; i++) begin
      d = DW'($urandom_range(0, 255));
      s_wdata = d; sb.push_back(d);
      tick();
    end
    s_rinc = 1;
    for (int i = 0; i < 40; i++) begin
      d = DW'($urandom_range(0, 255));
      s_wdata = d; sb.push_back(d);
      tick();
      exp = sb.pop_front();
      checks++;
      if ({s_rdata, s_count} !== {exp, 5'd3}) begin
        failures++;
        $display("FAIL wrap_%0d got rd=%h cnt=%0d want %h 3", i, s_rdata, s_count, exp);
      end
    end
    s_winc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp = sb.pop_front();
      checks++;
      if (s_rdata !== exp) begin
        failures++;
        $display("FAIL wrap_tail_%0d got rd=%h want %h", i, s_rdata, exp);
      end
    end
    s_rinc = 0;
  endtask

  task automatic test_rst_mid();
    s_rinc = 1;
    tick();
    s_rinc = 0;
    s_winc = 1;
    for (int i = 0; i < 9; i++) begin
      s_wdata = DW'(8'h90 + i);
      tick();
    end
    s_winc = 0;
    checks++;
    if ({s_count, s_rudf} !== {5'd9, 1'b1}) begin
      failures++;
      $display("FAIL pre_rst got cnt=%0d udf=%b want 9 1", s_count, s_rudf);
    end
    rst = 1; s_winc = 1; s_rinc = 1; s_wdata = 8'h55;
    tick();
    rst = 0; s_winc = 0; s_rinc = 0;
    sb.delete();
    checks++;
    if ({s_count, s_rempty, s_raempty, s_wfull, s_rdata, s_wovf, s_rudf} !==
        {5'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid got cnt=%0d re=%b rae=%b wf=%b rd=%h ovf=%b udf=%b",
               s_count, s_rempty, s_raempty, s_wfull, s_rdata, s_wovf, s_rudf);
    end
    s_winc = 1; s_wdata = 8'h77;
    tick();
    s_winc = 0; s_rinc = 1;
    tick();
    s_rinc = 0;
    checks++;
    if ({s_rdata, s_count} !== {8'h77, 5'd0}) begin
      failures++;
      $display("FAIL post_rst_read got rd=%h cnt=%0d want 77 0", s_rdata, s_count);
    end
  endtask

  task automatic test_fwft_single();
    f_winc = 1; f_wdata = 8'hA5;
    sb.push_back(8'hA5);
    tick();
    f_winc = 0;
    checks++;
    if ({f_rempty, f_count} !== {1'b1, 5'd1}) begin
      failures++;
      $display("FAIL fwft_lat1 got re=%b cnt=%0d want 1 1", f_rempty, f_count);
    end
    tick();
    checks++;
    if ({f_rempty, f_rdata} !== {1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL fwft_lat2 got re=%b rd=%h want 0 a5", f_rempty, f_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp;
    f_winc = 1;
    for (int i = 0; i < 4; i++) begin
      f_wdata = DW'(8'h11 + i);
      sb.push_back(DW'(8'h11 + i));
      tick();
    end
    f_winc = 0;
    checks++;
    if ({f_count, f_rempty, f_rdata} !== {5'd5, 1'b0, 8'hA5}) begin
      failures++;
      $display("FAIL fwft_loaded got cnt=%0d re=%b rd=%h want 5 0 a5", f_count, f_rempty, f_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      exp = sb.pop_front();
      checks++;
      if ({f_rempty, f_rdata, f_count} !== {1'b0, exp, 5'(5 - i)}) begin
        failures++;
        $display("FAIL fwft_stream_%0d got re=%b rd=%h cnt=%0d want 0 %h %0d", i, f_rempty,
                 f_rdata, f_count, exp, 5 - i);
      end
      f_rinc = 1;
      tick();
    end
    tick();
    f_rinc = 0;
    checks++;
    if ({f_rempty, f_count, f_rudf, f_wovf, f_wfull} !== {1'b1, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fwft_drained got re=%b cnt=%0d udf=%b ovf=%b wf=%b want 1 0 1 0 0",
               f_rempty, f_count, f_rudf, f_wovf, f_wfull);
    end
    f_clr = 1;
    tick();
    f_clr = 0;
    checks++;
    if ({f_rudf, f_raempty, f_wafull} !== 3'b010) begin
      failures++;
      $display("FAIL fwft_clr got udf=%b rae=%b waf=%b want 0 1 0", f_rudf, f_raempty, f_wafull);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_rst_mid();
    test_fwft_single();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
